controle_busca_quadrantes: RTL and testbench

- Sequences the four quadrant nearest-target searchers: 0 DireitaFrente, 1 DireitaTras, 2 EsquerdaFrente, 3 EsquerdaTras.
- Owns the shared search radius and the per-quadrant enables, and generates the raioAtualizado handshake.
- Merges the quadrant results into one minimum-distance target.
- Sits between the path planner (start/result) and the quadrant searcher instances.

---
 rtl/controle_busca_quadrantes.sv | 239 +++++++++++++++++++++++
 tb/tb_controle_busca_quadrantes.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_busca_quadrantes.sv
// Sequences the four quadrant searchers (radius, enables, raioAtualizado handshake) and merges their results.
// Optional per-round watchdog selected by macro TIMEOUT_EN; without it erroTimeout is tied 0.
module controle_busca_quadrantes #(
  parameter int TamanhoMalha     = 20,
  parameter int tamanhoDistancia = 8,
  parameter int LimiteCiclos     = 1023
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [tamanhoDistancia-1:0]   posicaoX,
  input  logic [tamanhoDistancia-1:0]   posicaoY,
  output logic [tamanhoDistancia-1:0]   posicaoAtualnoEixoX,
  output logic [tamanhoDistancia-1:0]   posicaoAtualnoEixoY,
  output logic                          limpaQuadrantes,
  output logic [3:0]                    quadEnable,
  output logic [tamanhoDistancia-1:0]   raio,
  output logic                          raioAtualizado,
  input  logic [3:0]                    quadAcabouLocal,
  input  logic [3:0]                    quadFinalizada,
  input  logic [4*tamanhoDistancia-1:0] quadCandidato,
  input  logic [4*tamanhoDistancia-1:0] quadCoordX,
  input  logic [4*tamanhoDistancia-1:0] quadCoordY,
  output logic                          ocupado,
  output logic                          pronto,
  output logic                          encontrado,
  output logic [tamanhoDistancia-1:0]   distanciaFinal,
  output logic [tamanhoDistancia-1:0]   alvoX,
  output logic [tamanhoDistancia-1:0]   alvoY,
  output logic                          erroTimeout
);

  localparam int W = tamanhoDistancia;
  localparam logic [W-1:0] RAIO_MAX = W'(TamanhoMalha - 1);
  localparam logic [W-1:0] SEM_CAND = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SEARCH, S_SETTLE, S_EVAL, S_PULSE, S_GUARD, S_DONE
  } estado_t;

  estado_t        estado_q, estado_d;
  logic [W-1:0]   posx_q, posx_d, posy_q, posy_d;
  logic [W-1:0]   raio_q, raio_d;
  logic [3:0]     en_q, en_d;
  logic           settle_q, settle_d;
  logic           fim_q, fim_d;
  logic           enc_q, enc_d;
  logic [W-1:0]   dist_q, dist_d, alvox_q, alvox_d, alvoy_q, alvoy_d;

  logic [W-1:0]   cand [4];
  logic [W-1:0]   cx   [4];
  logic [W-1:0]   cy   [4];
  logic [3:0]     sem_cand, valido, ativo_valido, bordas;
  logic           busca_completa, terminou, timeout_hit;
  logic           sel_achou;
  logic [W-1:0]   sel_dist, sel_x, sel_y;

  always_comb begin
    sem_cand = '0;
    valido   = '0;
    for (int i = 0; i < 4; i++) begin
      cand[i]     = quadCandidato[i*W +: W];
      cx[i]       = quadCoordX[i*W +: W];
      cy[i]       = quadCoordY[i*W +: W];
      sem_cand[i] = (cand[i] == SEM_CAND);
      valido[i]   = quadFinalizada[i] && !sem_cand[i];
    end
  end

  assign ativo_valido   = valido & en_q;
  // A quadrant that finalized with nothing has reached the grid edge.
  assign bordas         = en_q & quadFinalizada & sem_cand;
  assign busca_completa = ((quadAcabouLocal & en_q) == en_q);
  assign terminou       = (|ativo_valido) || ((quadFinalizada & en_q) == en_q) ||
                          (raio_q == RAIO_MAX);

  // Strict less-than keeps the lowest index on equal distances.
  always_comb begin
    sel_achou = 1'b0;
    sel_dist  = SEM_CAND;
    sel_x     = '0;
    sel_y     = '0;
    for (int i = 0; i < 4; i++) begin
      if (ativo_valido[i] && (!sel_achou || cand[i] < sel_dist)) begin
        sel_achou = 1'b1;
        sel_dist  = cand[i];
        sel_x     = cx[i];
        sel_y     = cy[i];
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    posx_d   = posx_q;
    posy_d   = posy_q;
    raio_d   = raio_q;
    en_d     = en_q;
    settle_d = settle_q;
    fim_d    = fim_q;
    enc_d    = enc_q;
    dist_d   = dist_q;
    alvox_d  = alvox_q;
    alvoy_d  = alvoy_q;
    case (estado_q)
      S_IDLE: begin
        if (start) begin
          posx_d   = posicaoX;
          posy_d   = posicaoY;
          raio_d   = W'(1);
          en_d     = '0;
          fim_d    = 1'b0;
          enc_d    = 1'b0;
          dist_d   = '0;
          alvox_d  = '0;
          alvoy_d  = '0;
          estado_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        en_d     = 4'b1111;
        estado_d = S_SEARCH;
      end
      S_SEARCH: begin
        if (busca_completa) begin
          settle_d = 1'b0;
          estado_d = S_SETTLE;
        end else if (timeout_hit) begin
          fim_d    = 1'b1;
          enc_d    = 1'b0;
          dist_d   = SEM_CAND;
          alvox_d  = '0;
          alvoy_d  = '0;
          estado_d = S_PULSE;
        end
      end
      S_SETTLE: begin
        settle_d = 1'b1;
        if (settle_q) estado_d = S_EVAL;
      end
      S_EVAL: begin
        if (terminou) begin
          fim_d   = 1'b1;
          enc_d   = sel_achou;
          dist_d  = sel_dist;
          alvox_d = sel_x;
          alvoy_d = sel_y;
        end else begin
          en_d   = en_q & ~bordas;
          raio_d = raio_q + 1'b1;
        end
        estado_d = S_PULSE;
      end
      S_PULSE: begin
        if (fim_q) begin
          en_d     = '0;
          estado_d = S_DONE;
        end else begin
          estado_d = S_GUARD;
        end
      end
      S_GUARD:  estado_d = S_SEARCH;
      S_DONE:   estado_d = S_IDLE;
      default:  estado_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= S_IDLE;
      posx_q   <= '0;
      posy_q   <= '0;
      raio_q   <= '0;
      en_q     <= '0;
      settle_q <= 1'b0;
      fim_q    <= 1'b0;
      enc_q    <= 1'b0;
      dist_q   <= '0;
      alvox_q  <= '0;
      alvoy_q  <= '0;
    end else begin
      estado_q <= estado_d;
      posx_q   <= posx_d;
      posy_q   <= posy_d;
      raio_q   <= raio_d;
      en_q     <= en_d;
      settle_q <= settle_d;
      fim_q    <= fim_d;
      enc_q    <= enc_d;
      dist_q   <= dist_d;
      alvox_q  <= alvox_d;
      alvoy_q  <= alvoy_d;
    end
  end

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(LimiteCiclos + 1);
  logic [CW-1:0] cnt_q;
  logic          tmo_q, erro_q;

  assign timeout_hit = (estado_q == S_SEARCH) && (cnt_q == CW'(LimiteCiclos - 1));
  assign erroTimeout = erro_q;

  // Counter sits at zero outside SEARCH, so every SEARCH entry starts a fresh round.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tmo_q  <= 1'b0;
      erro_q <= 1'b0;
    end else begin
      cnt_q <= (estado_q == S_SEARCH) ? cnt_q + 1'b1 : '0;
      if (estado_q == S_IDLE && start) begin
        tmo_q  <= 1'b0;
        erro_q <= 1'b0;
      end else begin
        if (timeout_hit && !busca_completa) tmo_q <= 1'b1;
        if (estado_q == S_PULSE && tmo_q)   erro_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign erroTimeout = 1'b0;
`endif

  assign posicaoAtualnoEixoX = posx_q;
  assign posicaoAtualnoEixoY = posy_q;
  assign limpaQuadrantes     = (estado_q == S_CLEAR);
  assign quadEnable          = en_q;
  assign raio                = raio_q;
  assign raioAtualizado      = (estado_q == S_PULSE);
  assign ocupado             = (estado_q != S_IDLE);
  assign pronto              = (estado_q == S_DONE);
  assign encontrado          = enc_q;
  assign distanciaFinal      = dist_q;
  assign alvoX               = alvox_q;
  assign alvoY               = alvoy_q;

endmodule

// File: tb/tb_controle_busca_quadrantes.sv
// Directed bench: a behavioural searcher stand-in answers each radius round from per-quadrant tables.
module tb_controle_busca_quadrantes;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  posicaoX, posicaoY;
  logic [7:0]  posicaoAtualnoEixoX, posicaoAtualnoEixoY;
  logic        limpaQuadrantes;
  logic [3:0]  quadEnable;
  logic [7:0]  raio;
  logic        raioAtualizado;
  logic [3:0]  quadAcabouLocal, quadFinalizada;
  logic [31:0] quadCandidato, quadCoordX, quadCoordY;
  logic        ocupado, pronto, encontrado;
  logic [7:0]  distanciaFinal, alvoX, alvoY;
  logic        erroTimeout;

  int vectors = 0;
  int miscompares = 0;

  // Searcher tables: radius at which each quadrant finalizes, its candidate (FF = none), coordinates.
  logic [7:0] m_fin  [4];
  logic [7:0] m_cand [4];
  logic [7:0] m_cx   [4];
  logic [7:0] m_cy   [4];
  logic [3:0] m_acabou;

  // Results observed during the last run.
  int         n_pulse, n_pronto, n_limpa, c_pronto;
  logic       r_enc, r_erro;
  logic [7:0] r_dist, r_x, r_y, r_raio, raio_first;
  logic [3:0] r_en, en_first;

  controle_busca_quadrantes #(
    .TamanhoMalha(20), .tamanhoDistancia(8), .LimiteCiclos(50)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .posicaoX(posicaoX), .posicaoY(posicaoY),
    .posicaoAtualnoEixoX(posicaoAtualnoEixoX), .posicaoAtualnoEixoY(posicaoAtualnoEixoY),
    .limpaQuadrantes(limpaQuadrantes), .quadEnable(quadEnable), .raio(raio),
    .raioAtualizado(raioAtualizado), .quadAcabouLocal(quadAcabouLocal),
    .quadFinalizada(quadFinalizada), .quadCandidato(quadCandidato),
    .quadCoordX(quadCoordX), .quadCoordY(quadCoordY), .ocupado(ocupado),
    .pronto(pronto), .encontrado(encontrado), .distanciaFinal(distanciaFinal),
    .alvoX(alvoX), .alvoY(alvoY), .erroTimeout(erroTimeout)
  );

  always #5 clock = ~clock;

  task automatic drive_model();
    logic [3:0]  fin;
    logic [31:0] cv, xv, yv;
    fin = '0; cv = '1; xv = '0; yv = '0;
    for (int i = 0; i < 4; i++) begin
      fin[i] = ocupado && (raio >= m_fin[i]);
      if (fin[i]) cv[i*8 +: 8] = m_cand[i];
      xv[i*8 +: 8] = m_cx[i];
      yv[i*8 +: 8] = m_cy[i];
    end
    quadAcabouLocal = ocupado ? m_acabou : 4'b0000;
    quadFinalizada  = fin;
    quadCandidato   = cv;
    quadCoordX      = xv;
    quadCoordY      = yv;
  endtask

  task automatic set_quad(input int i, input logic [7:0] f, c, x, y);
    m_fin[i] = f; m_cand[i] = c; m_cx[i] = x; m_cy[i] = y;
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 4; i++) set_quad(i, 8'd99, 8'hFF, 8'd0, 8'd0);
    m_acabou = 4'hF;
  endtask

  task automatic do_run(input logic [7:0] x, input logic [7:0] y, input bit inject);
    int post;
    n_pulse = 0; n_pronto = 0; n_limpa = 0; c_pronto = -1; post = 0;
    @(negedge clock);
    posicaoX = x; posicaoY = y; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 400 && post < 8; c++) begin
      if (raioAtualizado) begin
        n_pulse++;
        if (n_pulse == 1) begin en_first = quadEnable; raio_first = raio; end
      end
      if (limpaQuadrantes) n_limpa++;
      if (pronto) begin
        n_pronto++; c_pronto = c;
        r_enc = encontrado; r_dist = distanciaFinal; r_x = alvoX; r_y = alvoY;
        r_en = quadEnable; r_raio = raio; r_erro = erroTimeout;
      end
      if (n_pronto > 0) post++;
      if (inject && c == 3) begin
        start = 1'b1; posicaoX = 8'd1; posicaoY = 8'd1;
      end else begin
        start = 1'b0;
      end
      drive_model();
      @(negedge clock);
    end
    start = 1'b0;
    if (n_pronto == 0) begin
      vectors++; miscompares++;
      $display("FAIL run_timeout: got no pronto within budget, expected one");
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; posicaoX = '0; posicaoY = '0;
    clear_tables(); drive_model();
    repeat (3) @(negedge clock);
    vectors++;
    if ({posicaoAtualnoEixoX, posicaoAtualnoEixoY, limpaQuadrantes, quadEnable, raio, raioAtualizado,
         ocupado, pronto, encontrado, distanciaFinal, alvoX, alvoY, erroTimeout} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got raio=%0d en=%b ocupado=%b dist=%0d, expected all zero",
               raio, quadEnable, ocupado, distanciaFinal);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_target();
    clear_tables();
    set_quad(1, 8'd2, 8'd2, 8'd7, 8'd4);
    do_run(8'd5, 8'd5, 1'b0);
    vectors++; if (n_pulse !== 2) begin miscompares++; $display("FAIL target_pulses: got %0d expected 2", n_pulse); end
    vectors++; if (n_pronto !== 1) begin miscompares++; $display("FAIL target_pronto: got %0d expected 1", n_pronto); end
    vectors++; if (n_limpa !== 1) begin miscompares++; $display("FAIL target_limpa: got %0d expected 1", n_limpa); end
    vectors++; if (raio_first !== 8'd2) begin miscompares++; $display("FAIL target_raio_step: got %0d expected 2", raio_first); end
    vectors++; if ({r_enc, r_dist} !== {1'b1, 8'd2}) begin miscompares++; $display("FAIL target_dist: got enc=%b dist=%0d expected enc=1 dist=2", r_enc, r_dist); end
    vectors++; if ({r_x, r_y} !== {8'd7, 8'd4}) begin miscompares++; $display("FAIL target_alvo: got (%0d,%0d) expected (7,4)", r_x, r_y); end
    vectors++; if (r_en !== 4'b0000) begin miscompares++; $display("FAIL target_enable_off: got %b expected 0000", r_en); end
    vectors++; if (r_erro !== 1'b0) begin miscompares++; $display("FAIL target_erro: got %b expected 0", r_erro); end
    vectors++; if ({posicaoAtualnoEixoX, posicaoAtualnoEixoY} !== {8'd5, 8'd5}) begin miscompares++; $display("FAIL target_pos: got (%0d,%0d) expected (5,5)", posicaoAtualnoEixoX, posicaoAtualnoEixoY); end
    vectors++; if ({encontrado, distanciaFinal} !== {1'b1, 8'd2}) begin miscompares++; $display("FAIL target_hold: got enc=%b dist=%0d expected enc=1 dist=2", encontrado, distanciaFinal); end
  endtask

  task automatic test_tie();
    clear_tables();
    set_quad(0, 8'd1, 8'd1, 8'd6, 8'd6);
    set_quad(3, 8'd1, 8'd1, 8'd4, 8'd4);
    do_run(8'd5, 8'd5, 1'b0);
    vectors++; if (n_pulse !== 1) begin miscompares++; $display("FAIL tie_pulses: got %0d expected 1", n_pulse); end
    vectors++; if ({r_enc, r_dist, r_x, r_y} !== {1'b1, 8'd1, 8'd6, 8'd6}) begin miscompares++; $display("FAIL tie_winner: got enc=%b dist=%0d (%0d,%0d) expected enc=1 dist=1 (6,6)", r_enc, r_dist, r_x, r_y); end
  endtask

  task automatic test_minimum();
    clear_tables();
    set_quad(1, 8'd1, 8'd4, 8'd9, 8'd1);
    set_quad(2, 8'd1, 8'd3, 8'd2, 8'd8);
    do_run(8'd5, 8'd5, 1'b0);
    vectors++; if ({r_enc, r_dist, r_x, r_y} !== {1'b1, 8'd3, 8'd2, 8'd8}) begin miscompares++; $display("FAIL min_winner: got enc=%b dist=%0d (%0d,%0d) expected enc=1 dist=3 (2,8)", r_enc, r_dist, r_x, r_y); end
  endtask

  task automatic test_empty_grid();
    clear_tables();
    set_quad(0, 8'd1, 8'hFF, 8'd0, 8'd0);
    set_quad(1, 8'd1, 8'hFF, 8'd0, 8'd0);
    do_run(8'd19, 8'd0, 1'b0);
    vectors++; if (en_first !== 4'b1100) begin miscompares++; $display("FAIL empty_edge_enables: got %b expected 1100", en_first); end
    vectors++; if (n_pulse !== 19) begin miscompares++; $display("FAIL empty_pulses: got %0d expected 19", n_pulse); end
    vectors++; if (r_raio !== 8'd19) begin miscompares++; $display("FAIL empty_raio_max: got %0d expected 19", r_raio); end
    vectors++; if ({r_enc, r_dist, r_x, r_y} !== {1'b0, 8'hFF, 8'd0, 8'd0}) begin miscompares++; $display("FAIL empty_result: got enc=%b dist=%0h (%0d,%0d) expected enc=0 dist=ff (0,0)", r_enc, r_dist, r_x, r_y); end
  endtask

  task automatic test_all_finalized();
    clear_tables();
    for (int i = 0; i < 4; i++) set_quad(i, 8'd2, 8'hFF, 8'd0, 8'd0);
    do_run(8'd10, 8'd10, 1'b0);
    vectors++; if (n_pulse !== 2) begin miscompares++; $display("FAIL allfin_pulses: got %0d expected 2", n_pulse); end
    vectors++; if ({r_enc, r_dist} !== {1'b0, 8'hFF}) begin miscompares++; $display("FAIL allfin_result: got enc=%b dist=%0h expected enc=0 dist=ff", r_enc, r_dist); end
  endtask

  task automatic test_ignored_start();
    clear_tables();
    set_quad(2, 8'd1, 8'd1, 8'd2, 8'd5);
    do_run(8'd3, 8'd4, 1'b1);
    vectors++; if (n_pronto !== 1) begin miscompares++; $display("FAIL ignore_pronto: got %0d expected 1", n_pronto); end
    vectors++; if ({posicaoAtualnoEixoX, posicaoAtualnoEixoY} !== {8'd3, 8'd4}) begin miscompares++; $display("FAIL ignore_pos: got (%0d,%0d) expected (3,4)", posicaoAtualnoEixoX, posicaoAtualnoEixoY); end
    vectors++; if (ocupado !== 1'b0) begin miscompares++; $display("FAIL ignore_idle: got ocupado=%b expected 0", ocupado); end
  endtask

  task automatic test_reset_mid_search();
    int np;
    bit hit;
    clear_tables();
    hit = 0; np = 0;
    @(negedge clock);
    posicaoX = 8'd5; posicaoY = 8'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (raio == 8'd3) hit = 1;
      else begin drive_model(); @(negedge clock); end
    end
    vectors++;
    if (!hit) begin miscompares++; $display("FAIL midreset_reach: got raio=%0d expected 3 within budget", raio); end
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({raio, quadEnable, ocupado, pronto, raioAtualizado, limpaQuadrantes, posicaoAtualnoEixoX} !== '0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got raio=%0d en=%b ocupado=%b expected all zero", raio, quadEnable, ocupado);
    end
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      drive_model();
      @(negedge clock);
      if (pronto || ocupado) np++;
    end
    vectors++; if (np !== 0) begin miscompares++; $display("FAIL midreset_no_pronto: got %0d busy/pronto cycles expected 0", np); end
  endtask

`ifdef TIMEOUT_EN
  task automatic test_timeout();
    clear_tables();
    m_acabou = 4'b0000;
    do_run(8'd5, 8'd5, 1'b0);
    vectors++; if (c_pronto !== 52) begin miscompares++; $display("FAIL tmo_cycle: got %0d expected 52", c_pronto); end
    vectors++; if ({r_erro, r_enc, r_en} !== {1'b1, 1'b0, 4'b0000}) begin miscompares++; $display("FAIL tmo_flags: got erro=%b enc=%b en=%b expected erro=1 enc=0 en=0000", r_erro, r_enc, r_en); end
    vectors++; if (n_pulse !== 1) begin miscompares++; $display("FAIL tmo_pulses: got %0d expected 1", n_pulse); end
    m_acabou = 4'hF;
  endtask
`endif

  initial begin
    test_reset();
    test_target();
    test_tie();
    test_minimum();
    test_empty_grid();
    test_all_finalized();
    test_ignored_start();
    test_reset_mid_search();
`ifdef TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
